// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-side types: RAM handshake state, bus word, and the arbiter's
// FSM state and request-kind encodings.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    IREAD  = 2'd0,
    DREAD  = 2'd1,
    DWRITE = 2'd2
  } req_kind_t;

  // Transaction captured at grant time; the owner may change its bus afterwards.
  typedef struct packed {
    req_kind_t kind;
    word_t     addr;
    word_t     data;
  } xact_t;

  function automatic logic is_data(input req_kind_t kind);
    return kind != IREAD;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection: data beats instruction, and within each class
// the first requesting core at or after rr_ptr (modulo CPUS) wins.
module rr_picker
  import cpu_types_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int CORE_W = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic [CPUS-1:0]   iren,
  input  logic [CPUS-1:0]   dren,
  input  logic [CPUS-1:0]   dwen,
  input  logic [CORE_W-1:0] rr_ptr,
  output logic [CORE_W-1:0] win_core,
  output req_kind_t         win_kind,
  output logic              win_valid
);

  logic [CORE_W:0]   sum;
  logic [CORE_W-1:0] idx;
  logic              data_found;
  logic              data_wr;
  logic [CORE_W-1:0] data_core;
  logic              instr_found;
  logic [CORE_W-1:0] instr_core;

  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    sum         = '0;
    idx         = '0;
    data_found  = 1'b0;
    data_wr     = 1'b0;
    data_core   = '0;
    instr_found = 1'b0;
    instr_core  = '0;
    for (int i = 0; i < CPUS; i++) begin
      sum = {1'b0, rr_ptr} + (CORE_W+1)'(i);
      if (sum >= (CORE_W+1)'(CPUS)) begin
        sum = sum - (CORE_W+1)'(CPUS);
      end
      idx = sum[CORE_W-1:0];
      if (!data_found && (dren[idx] || dwen[idx])) begin
        data_found = 1'b1;
        data_core  = idx;
        // dREN and dWEN together is served as a write.
        data_wr    = dwen[idx];
      end
      if (!instr_found && iren[idx]) begin
        instr_found = 1'b1;
        instr_core  = idx;
      end
    end
  end

  always_comb begin
    win_valid = data_found || instr_found;
    win_core  = data_found ? data_core : instr_core;
    win_kind  = IREAD;
    if (data_found) begin
      win_kind = data_wr ? DWRITE : DREAD;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Registered arbiter multiplexing every core's icache/dcache bus onto one RAM port;
// a granted transaction owns RAM until ramstate reports ACCESS.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic      [CPUS-1:0]   iREN,
  input  logic      [CPUS-1:0]   dREN,
  input  logic      [CPUS-1:0]   dWEN,
  input  word_t     [CPUS-1:0]   iaddr,
  input  word_t     [CPUS-1:0]   daddr,
  input  word_t     [CPUS-1:0]   dstore,
  output logic      [CPUS-1:0]   iwait,
  output logic      [CPUS-1:0]   dwait,
  output word_t     [CPUS-1:0]   iload,
  output word_t     [CPUS-1:0]   dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output word_t                  ramaddr,
  output word_t                  ramstore,
  input  word_t                  ramload,
  input  ramstate_t              ramstate
);

  localparam int CORE_W = (CPUS > 1) ? $clog2(CPUS) : 1;

  arb_state_t              state_q, state_d;
  xact_t                   xact_q, win_xact;
  logic      [CORE_W-1:0]  owner_q;
  logic      [CORE_W-1:0]  rr_ptr_q;
  logic      [CORE_W-1:0]  rr_next;
  word_t     [CPUS-1:0]    iload_q;
  word_t     [CPUS-1:0]    dload_q;

  logic      [CORE_W-1:0]  win_core;
  req_kind_t               win_kind;
  logic                    win_valid;
  logic                    owner_req;
  logic                    access;
  logic                    abort;
  logic                    take;

  rr_picker #(
    .CPUS   (CPUS),
    .CORE_W (CORE_W)
  ) u_picker (
    .iren      (iREN),
    .dren      (dREN),
    .dwen      (dWEN),
    .rr_ptr    (rr_ptr_q),
    .win_core  (win_core),
    .win_kind  (win_kind),
    .win_valid (win_valid)
  );

  always_comb begin
    win_xact      = '0;
    win_xact.kind = win_kind;
    win_xact.addr = is_data(win_kind) ? daddr[win_core] : iaddr[win_core];
    win_xact.data = dstore[win_core];
  end

  // The owner is still interested while its request line for the granted kind stays high.
  assign owner_req = is_data(xact_q.kind) ? (dREN[owner_q] || dWEN[owner_q])
                                          : iREN[owner_q];
  assign access    = (state_q == GRANT) && (ramstate == ACCESS);
  assign abort     = (state_q == GRANT) && !access && !owner_req;
  assign take      = (state_q == IDLE) && win_valid;
  assign rr_next   = (owner_q == CORE_W'(CPUS - 1)) ? '0 : owner_q + CORE_W'(1);

  // Strobes follow the registered state, so reset or abort drops them without a comb path from requests.
  assign ramREN   = (state_q == GRANT) && (xact_q.kind != DWRITE);
  assign ramWEN   = (state_q == GRANT) && (xact_q.kind == DWRITE);
  assign ramaddr  = xact_q.addr;
  assign ramstore = xact_q.data;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_valid)        state_d = GRANT;
      GRANT:   if (access || abort)  state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      xact_q   <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      iload_q  <= '0;
      dload_q  <= '0;
    end else begin
      if (take) begin
        xact_q  <= win_xact;
        owner_q <= win_core;
      end
      if (access) begin
        rr_ptr_q <= rr_next;
        if (xact_q.kind == IREAD) begin
          iload_q[owner_q] <= ramload;
        end else if (xact_q.kind == DREAD) begin
          dload_q[owner_q] <= ramload;
        end
      end
    end
  end

  // Completion is combinational in the ACCESS cycle; registered copies keep loads stable afterwards.
  always_comb begin
    iwait = '1;
    dwait = '1;
    iload = iload_q;
    dload = dload_q;
    if (access) begin
      if (xact_q.kind == IREAD) begin
        iwait[owner_q] = 1'b0;
        iload[owner_q] = ramload;
      end else begin
        dwait[owner_q] = 1'b0;
        // A write returns no data, so dload keeps its previous value.
        if (xact_q.kind == DREAD) begin
          dload[owner_q] = ramload;
        end
      end
    end
  end

endmodule
